// File: rtl/piso_frame_tx_pkg.sv
// Shared types and helpers for the PISO frame transmitter.
package piso_frame_tx_pkg;

  // Frame sequencer states.
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  // Serial level driven when no data bit is being sent.
  localparam logic IDLE_LVL_DEF = 1'b0;

  // Width of the slot counter: ceil(log2(n)), never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// Single-entry valid/ready holding register. The word is popped by the
// frame sequencer when it loads it; a new word may be accepted on the
// same edge as the pop.
module piso_hold_buf
  import piso_frame_tx_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_pop,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_vld,
  output logic              o_vld_nxt
);

  logic              r_vld;
  logic [DATA_W-1:0] r_data;
  logic              w_accept;

  // Handshake decode: room exists when empty or when the word leaves this edge.
  always_comb begin
    o_ready   = i_en && (!r_vld || i_pop);
    w_accept  = i_valid && o_ready;
    o_vld_nxt = w_accept || (r_vld && !i_pop);
  end

  // Holding register state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else begin
      r_vld <= o_vld_nxt;
      if (w_accept) begin
        r_data <= i_data;
      end else begin
        r_data <= r_data;
      end
    end
  end

  assign o_data = r_data;
  assign o_vld  = r_vld;

endmodule

// File: rtl/piso_frame_tx.sv
// Parallel-in serial-out frame transmitter: one buffered byte, LSB-first
// shifting into fixed-length frames, back-to-back when the buffer is kept full.
module piso_frame_tx
  import piso_frame_tx_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FRAME_LEN   = 8,
  parameter int unsigned ACTIVE_BITS = 8,
  parameter logic        IDLE_LVL    = IDLE_LVL_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              d_out,
  output logic              frame_start,
  output logic              busy
);

  localparam int unsigned      CNT_W    = cnt_width(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] ACT_LAST = CNT_W'(ACTIVE_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            r_state;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_shreg;
  logic              r_run;
  logic              r_d_out;
  logic              r_frame_start;
  logic              r_busy;

  logic              w_load;
  logic [DATA_W-1:0] w_hold_q;
  logic              w_hold_vld;
  logic              w_hold_vld_nxt;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [DATA_W-1:0] w_shreg_nxt;
  logic              w_d_out_nxt;
  logic              w_fs_nxt;
  logic              w_busy_nxt;

  // r_run keeps in_ready low while reset is held and until the first clock after release.
  piso_hold_buf #(
    .DATA_W (DATA_W)
  ) u_hold (
    .i_clk     (clock),
    .i_rst_n   (reset),
    .i_en      (r_run),
    .i_data    (in_data),
    .i_valid   (in_valid),
    .i_pop     (w_load),
    .o_ready   (in_ready),
    .o_data    (w_hold_q),
    .o_vld     (w_hold_vld),
    .o_vld_nxt (w_hold_vld_nxt)
  );

  // Next-state decode for the frame sequencer and the outputs it drives.
  always_comb begin
    w_load      = w_hold_vld && ((r_state == S_IDLE) || (r_count == CNT_LAST));
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_shreg_nxt = r_shreg;
    if (w_load) begin
      w_state_nxt = S_SHIFT;
      w_count_nxt = '0;
      w_shreg_nxt = w_hold_q;
    end else if (r_state == S_SHIFT) begin
      if (r_count == CNT_LAST) begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end else begin
        w_count_nxt = r_count + CNT_ONE;
        // Stop shifting once the last active bit is on the line; unused slots ignore shreg.
        if (r_count < ACT_LAST) begin
          w_shreg_nxt = r_shreg >> 1;
        end else begin
          w_shreg_nxt = r_shreg;
        end
      end
    end else begin
      w_state_nxt = S_IDLE;
      w_count_nxt = r_count;
    end

    if ((w_state_nxt == S_SHIFT) && (w_count_nxt <= ACT_LAST)) begin
      w_d_out_nxt = w_shreg_nxt[0];
    end else begin
      w_d_out_nxt = IDLE_LVL;
    end
    w_fs_nxt   = (w_state_nxt == S_SHIFT) && (w_count_nxt == '0);
    w_busy_nxt = (w_state_nxt == S_SHIFT) || w_hold_vld_nxt;
  end

  // Sequencer state and registered serial outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_shreg       <= '0;
      r_run         <= 1'b0;
      r_d_out       <= IDLE_LVL;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_count       <= w_count_nxt;
      r_shreg       <= w_shreg_nxt;
      r_run         <= 1'b1;
      r_d_out       <= w_d_out_nxt;
      r_frame_start <= w_fs_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign d_out       = r_d_out;
  assign frame_start = r_frame_start;
  assign busy        = r_busy;

endmodule

// File: tb/tb_piso_frame_tx.sv
// Bench for piso_frame_tx: directed and random traffic against a frame-timing model.
module tb_piso_frame_tx;

  localparam int FRAME_LEN = 8;
  localparam int ACT       = 8;
  localparam logic IDLE    = 1'b0;

  logic       clock;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       d_out;
  logic       frame_start;
  logic       busy;

  logic [7:0] in_data5;
  logic       in_valid5;
  logic       in_ready5;
  logic       d_out5;
  logic       frame_start5;
  logic       busy5;

  int checks;
  int failures;
  int cyc;

  // Model: each accepted word has accept edge a and load edge s; slot k is cycle s+k.
  int         q_a[$];
  int         q_s[$];
  logic [7:0] q_d[$];

  piso_frame_tx u_dut (
    .clock       (clock),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .d_out       (d_out),
    .frame_start (frame_start),
    .busy        (busy)
  );

  piso_frame_tx #(.ACTIVE_BITS(5)) u_dut5 (
    .clock       (clock),
    .reset       (reset),
    .in_data     (in_data5),
    .in_valid    (in_valid5),
    .in_ready    (in_ready5),
    .d_out       (d_out5),
    .frame_start (frame_start5),
    .busy        (busy5)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void push(input int a, input logic [7:0] d);
    int s;
    s = a + 1;
    if (q_s.size() > 0 && q_s[$] + FRAME_LEN > s) s = q_s[$] + FRAME_LEN;
    q_a.push_back(a);
    q_s.push_back(s);
    q_d.push_back(d);
  endfunction

  function automatic void model_expect(input int n, output logic e_d, output logic e_fs,
                                       output logic e_busy, output logic e_rdy);
    int k;
    e_d = IDLE; e_fs = 1'b0; e_busy = 1'b0; e_rdy = 1'b1;
    for (int i = 0; i < q_s.size(); i++) begin
      if (n >= q_s[i] && n < q_s[i] + FRAME_LEN) begin
        k = n - q_s[i];
        e_busy = 1'b1;
        e_fs = (k == 0);
        e_d = (k < ACT) ? q_d[i][k] : IDLE;
      end
      if (q_a[i] <= n && n < q_s[i]) begin
        e_busy = 1'b1;
        e_rdy = (q_s[i] == n + 1);
      end
    end
  endfunction

  // One clock: drive inputs, check the current cycle at negedge, record any accept.
  task automatic step(input logic v, input logic [7:0] d, output logic acc);
    logic e_d, e_fs, e_busy, e_rdy;
    in_valid = v;
    in_data  = d;
    @(negedge clock);
    model_expect(cyc, e_d, e_fs, e_busy, e_rdy);
    chk("d_out", d_out, e_d);
    chk("frame_start", frame_start, e_fs);
    chk("busy", busy, e_busy);
    chk("in_ready", in_ready, e_rdy);
    acc = v && e_rdy;
    @(posedge clock);
    cyc++;
    if (acc) push(cyc, d);
    #1;
  endtask

  task automatic idle_steps(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, acc);
  endtask

  task automatic chk_reset_outs();
    chk("rst_d_out", d_out, IDLE);
    chk("rst_frame_start", frame_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_in_ready5", in_ready5, 1'b0);
  endtask

  task automatic restart();
    reset = 1'b0; in_valid = 1'b0; in_valid5 = 1'b0;
    #1;
    chk_reset_outs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_reset_outs();
    reset = 1'b1;
    @(posedge clock);
    cyc = 0;
    q_a.delete(); q_s.delete(); q_d.delete();
    #1;
  endtask

  initial begin
    logic       acc;
    logic       pv;
    logic [7:0] pd;
    logic [7:0] words [3];
    int         idx;
    int         guard;
    int         s3c;
    logic [15:0] exp5;
    logic [4:0]  sipo;
    int          sc;

    clock = 1'b0; reset = 1'b0;
    in_data = 8'h00; in_valid = 1'b0; in_data5 = 8'h00; in_valid5 = 1'b0;
    checks = 0; failures = 0; cyc = 0;

    // Reset, then idle line.
    restart();
    idle_steps(20);

    // Single word 0xA5.
    step(1'b1, 8'hA5, acc);
    chk("a5_accept", acc, 1'b1);
    idle_steps(12);

    // Streaming with valid held high.
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
    idx = 0; guard = 0;
    while (idx < 3 && guard < 100) begin
      step(1'b1, words[idx], acc);
      if (acc) idx++;
      guard++;
    end
    chk("stream_timeout", {7'd0, (guard >= 100)}, 8'd0);
    idle_steps(30);

    // Random traffic; the source holds a word until it is taken.
    pv = 1'b0; pd = 8'h00;
    for (int i = 0; i < 300; i++) begin
      if (!pv && $urandom_range(0, 2) != 0) begin
        pv = 1'b1;
        pd = 8'($urandom);
      end
      step(pv, pd, acc);
      if (acc) pv = 1'b0;
    end
    idle_steps(20);

    // New word offered in the last slot with the buffer empty.
    step(1'b1, 8'h5A, acc);
    guard = 0;
    while (cyc < q_s[$] + FRAME_LEN - 1 && guard < 50) begin
      step(1'b0, 8'h00, acc);
      guard++;
    end
    step(1'b1, 8'hC3, acc);
    chk("last_slot_accept", acc, 1'b1);
    idle_steps(14);

    // Reset in slot 3 of 0x3C with 0x55 buffered.
    step(1'b1, 8'h3C, acc);
    s3c = q_s[$];
    step(1'b1, 8'h55, acc);
    chk("buf_55_accept", acc, 1'b1);
    guard = 0;
    while (cyc < s3c + 3 && guard < 50) begin
      step(1'b0, 8'h00, acc);
      guard++;
    end
    reset = 1'b0;
    #1;
    chk("abort_d_out", d_out, IDLE);
    chk("abort_busy", busy, 1'b0);
    restart();
    idle_steps(15);

    // Five active bits: 0x1F then 0xF6 back to back, with a 5-bit capture on frame_start.
    exp5 = 16'h161F;
    sipo = 5'd0; sc = 5;
    for (int n = 0; n < 22; n++) begin
      in_valid5 = (n < 2);
      in_data5  = (n == 0) ? 8'h1F : 8'hF6;
      @(negedge clock);
      if (n < 2) chk("rdy5", in_ready5, 1'b1);
      chk("d_out5", d_out5, (n >= 2 && n < 18) ? exp5[n-2] : IDLE);
      chk("frame_start5", frame_start5, (n == 2 || n == 10));
      chk("busy5", busy5, (n >= 1 && n < 18));
      if (frame_start5) sc = 0;
      if (sc < 5) begin
        sipo = {d_out5, sipo[4:1]};
        sc++;
      end
      if (n == 6)  chk("sipo5_f1", {3'd0, sipo}, 8'h1F);
      if (n == 14) chk("sipo5_f2", {3'd0, sipo}, 8'h16);
      @(posedge clock);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_frame_tx.md
Name: piso_frame_tx

Overview:
Upstream serializer feeding the SIPO capture stage. Accepts parallel bytes over a valid/ready handshake, buffers one byte, and shifts each byte out LSB-first on a single serial line in fixed-length frames of FRAME_LEN clocks. Its output is the serial d_in of the downstream SIPO. Back-to-back frames run with no idle clocks when the buffer is kept full.

Parameters:
DATA_W, 8, parallel word width
FRAME_LEN, 8, clocks per frame (slot count); >= ACTIVE_BITS
ACTIVE_BITS, 8, data bits driven per frame (slots 0..ACTIVE_BITS-1); 1..DATA_W; set to 5 when pairing with the 5-bit capture variant
IDLE_LVL, 1'b0, serial level driven in idle state and in unused slots

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
in_data  in  DATA_W  parallel word
in_valid  in  1  in_data valid
in_ready  out  1  block can accept in_data this cycle
d_out  out  1  serial data, LSB first
frame_start  out  1  high during slot 0 of every frame
busy  out  1  frame in progress or word buffered

Behaviour:
- Reset (reset=0, async): state=IDLE, count=0, shreg=0, hold_vld=0; d_out=IDLE_LVL, frame_start=0, busy=0, in_ready=0 while reset is low.
- States: IDLE, SHIFT. count width = clog2(FRAME_LEN), min 1.
- Holding register hold_q/hold_vld: in_ready = !hold_vld || load. Accept on an edge with in_valid && in_ready -> hold_q<=in_data, hold_vld<=1.
- load = hold_vld && (state==IDLE || count==FRAME_LEN-1).
- On load: shreg<=hold_q, count<=0, state<=SHIFT, and hold_vld<=0 unless a new word is accepted on the same edge (then hold_vld stays 1 with the new data).
- SHIFT, no load: count<=count+1 and shreg<=shreg>>1 while count<ACTIVE_BITS-1; shreg holds otherwise. At count==FRAME_LEN-1 with no hold_vld: state<=IDLE, count<=0.
- d_out = shreg[0] when state==SHIFT && count<ACTIVE_BITS, else IDLE_LVL. It is decoded from registers only, with no combinational path from the inputs.
- frame_start = (state==SHIFT && count==0).
- busy = (state==SHIFT) || hold_vld.
- Latency: word accepted at edge E0 -> loaded at E1 -> bit0 on d_out in the cycle after E1, bit k in slot k.
- Back-to-back: the next frame's slot 0 immediately follows slot FRAME_LEN-1.
- in_valid while the buffer is full and no load occurs: in_ready=0, and in_data is ignored (not lost; source holds it).
- Bits DATA_W-1..ACTIVE_BITS of a word are discarded.
- Reset mid-frame aborts the frame and drops the buffered word. d_out returns to IDLE_LVL asynchronously.

Decomposition:
- Shared package: state enum (IDLE, SHIFT), IDLE_LVL default constant, clog2-based count width function.
- One natural sub-module, piso_hold_buf: the single-entry valid/ready holding register with a load/pop input. Shift/count/FSM stays in the top.

Test Plan:
- Reset then idle, no in_valid for 20 clocks -> d_out=0, busy=0, frame_start=0, in_ready=1 after reset release.
- Single word 0xA5 (defaults) -> frame_start for 1 cycle two clocks after accept; d_out slots 0..7 = 1,0,1,0,0,1,0,1; then IDLE, busy=0.
- Streaming 0x01, 0x80, 0xFF with in_valid held high -> 24 contiguous slots with frame_start every 8 clocks and no idle gap. in_ready drops while the buffer is full and reasserts on each load edge.
- ACTIVE_BITS=5, FRAME_LEN=8, word 0x1F -> slots 0..4 = 1, slots 5..7 = IDLE_LVL. Downstream SIPO aligned on frame_start captures 5 ones.
- Assert reset at slot 3 of 0x3C with 0x55 buffered -> d_out=0 immediately, busy=0. After release, no frame starts until a new accept. 0x55 is never transmitted.
- in_valid during the last slot with the buffer empty -> accept and load on the same edge path. The new frame follows after exactly one IDLE cycle (word enters hold at that edge, loads next edge), with no data corruption.
